// File: rtl/sr_bank_driver_pkg.sv
// Shared types and constants for the SR flop bank driver.
//   state_t      : controller states
//   SR_*         : per-bit {s, r} excitation encodings
//   retry_width(): width of the retry counter for a given MAX_RETRY
package sr_bank_driver_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      DRIVE   = 2'd1,
      RELEASE = 2'd2,
      CHECK   = 2'd3
   } state_t;

   localparam logic [1:0] SR_HOLD    = 2'b00;
   localparam logic [1:0] SR_RESET   = 2'b01;
   localparam logic [1:0] SR_SET     = 2'b10;
   // Forbidden combination; only used by checkers.
   localparam logic [1:0] SR_INVALID = 2'b11;

   // clog2(max_retry+1), never below 1 bit.
   function automatic int retry_width(input int max_retry);
      int w;
      w = $clog2(max_retry + 1);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/sr_bank_driver_excite_bit.sv
// Single-bit SR excitation encoder.
// Ports:
//   target : desired q
//   q      : current q of the flop
//   sr     : {s, r}; set when a 0 must become 1, reset when a 1 must become 0,
//            hold otherwise. Never produces {1, 1}.
module sr_excite_bit
   import sr_bank_driver_pkg::*;
(
   input  logic       target,
   input  logic       q,
   output logic [1:0] sr
);

   always_comb begin
      sr = SR_HOLD;
      if (target && !q)
         sr = SR_SET;
      else if (!target && q)
         sr = SR_RESET;
   end

endmodule

// File: rtl/sr_bank_driver.sv
// Driver for a bank of W clocked SR flops: accepts a target word, drives s/r
// from the excitation table for PULSE_CYCLES cycles, releases for one cycle,
// checks q_fb and retries up to MAX_RETRY times on mismatch.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake, req_target is the desired word
//   q_fb                  : q outputs read back from the bank
//   s, r                  : set/reset lines to the bank (never both 1 per bit)
//   busy                  : transaction in progress
//   done / err            : one-cycle result pulses (match / retries exhausted)
//   err_cnt               : saturating err pulse count, present only when
//                           SR_BANK_DRIVER_ERRCNT_EN is defined
// All outputs are registered.
//
// state   | meaning
// IDLE    | ready for a request; done/err pulse is visible here
// DRIVE   | s/r held at the latched excitation for PULSE_CYCLES cycles
// RELEASE | s=r=0 for one cycle while the bank settles
// CHECK   | compare q_fb with target; finish, retry or fail
module sr_bank_driver
   import sr_bank_driver_pkg::*;
#(
   parameter int W            = 4,
   parameter int PULSE_CYCLES = 1,
   parameter int MAX_RETRY    = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [W-1:0] req_target,
   input  logic [W-1:0] q_fb,
   output logic [W-1:0] s,
   output logic [W-1:0] r,
   output logic         busy,
   output logic         done,
   output logic         err
`ifdef SR_BANK_DRIVER_ERRCNT_EN
   ,
   output logic [7:0]   err_cnt
`endif
);

   localparam int RW = retry_width(MAX_RETRY);
   localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
   localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

   state_t          state_q, state_nxt;
   logic [W-1:0]    target_q, target_nxt;
   logic [RW-1:0]   retry_q, retry_nxt;
   logic [PW-1:0]   pulse_q, pulse_nxt;
   logic [W-1:0]    s_nxt, r_nxt;
   logic            done_nxt, err_nxt;
   logic [W-1:0]    tgt_sel;
   logic [W-1:0]    exc_s, exc_r;
   logic            match;

   // In IDLE the target register is not yet loaded, so the excitation for
   // the first drive comes straight from the request word.
   assign tgt_sel = (state_q == IDLE) ? req_target : target_q;
   assign match   = (q_fb == target_q);

   for (genvar i = 0; i < W; i++) begin : g_bit
      logic [1:0] sr_b;
      sr_excite_bit u_excite (
         .target (tgt_sel[i]),
         .q      (q_fb[i]),
         .sr     (sr_b)
      );
      assign exc_s[i] = sr_b[1];
      assign exc_r[i] = sr_b[0];
   end

   always_comb begin
      state_nxt  = state_q;
      target_nxt = target_q;
      retry_nxt  = retry_q;
      pulse_nxt  = pulse_q;
      s_nxt      = s;
      r_nxt      = r;
      done_nxt   = 1'b0;
      err_nxt    = 1'b0;
      case (state_q)
         IDLE: begin
            s_nxt = '0;
            r_nxt = '0;
            if (req_valid) begin
               target_nxt = req_target;
               retry_nxt  = '0;
               pulse_nxt  = PULSE_LOAD;
               s_nxt      = exc_s;
               r_nxt      = exc_r;
               state_nxt  = DRIVE;
            end
         end
         DRIVE: begin
            if (pulse_q == '0) begin
               s_nxt     = '0;
               r_nxt     = '0;
               state_nxt = RELEASE;
            end else begin
               pulse_nxt = pulse_q - 1'b1;
            end
         end
         RELEASE: begin
            s_nxt     = '0;
            r_nxt     = '0;
            state_nxt = CHECK;
         end
         CHECK: begin
            s_nxt = '0;
            r_nxt = '0;
            if (match) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else if (retry_q < RETRY_MAX) begin
               retry_nxt = retry_q + 1'b1;
               pulse_nxt = PULSE_LOAD;
               s_nxt     = exc_s;
               r_nxt     = exc_r;
               state_nxt = DRIVE;
            end else begin
               err_nxt   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            s_nxt     = '0;
            r_nxt     = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         target_q  <= '0;
         retry_q   <= '0;
         pulse_q   <= '0;
         s         <= '0;
         r         <= '0;
         req_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         target_q  <= target_nxt;
         retry_q   <= retry_nxt;
         pulse_q   <= pulse_nxt;
         s         <= s_nxt;
         r         <= r_nxt;
         req_ready <= (state_nxt == IDLE);
         busy      <= (state_nxt != IDLE);
         done      <= done_nxt;
         err       <= err_nxt;
      end
   end

`ifdef SR_BANK_DRIVER_ERRCNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_cnt <= '0;
      else if (err_nxt && (err_cnt != 8'hFF))
         err_cnt <= err_cnt + 8'd1;
   end
`endif

endmodule
